// File: rtl/inst_issue_queue.sv
// Instruction issue queue: circular buffer fed by a FETCH_W-wide fetch group,
// issuing up to ISSUE_W instructions per cycle in program order, with branch
// delay-slot pairing, serialising-instruction isolation and slot0->slot1 RAW
// splitting.

// Per-slot decoder: classifies an instruction word and extracts its
// register fields.
module iiq_decode (
  input  logic [31:0] inst,
  output logic        is_br,
  output logic        is_ser,
  output logic [4:0]  dest,
  output logic [4:0]  rs,
  output logic [4:0]  rt
);
  logic [5:0] op, fn;
  logic [4:0] rd;
  logic       unused_shamt;

  assign op           = inst[31:26];
  assign fn           = inst[5:0];
  assign rs           = inst[25:21];
  assign rt           = inst[20:16];
  assign rd           = inst[15:11];
  assign unused_shamt = ^inst[10:6];

  // Branch/serialising classification and destination register select.
  always_comb begin
    is_br  = (op >= 6'h01 && op <= 6'h07) ||
             (op == 6'h00 && (fn == 6'h08 || fn == 6'h09));
    is_ser = (op == 6'h10) || (op == 6'h1c) ||
             (op == 6'h00 && (fn == 6'h0c || fn == 6'h0d ||
                              (fn >= 6'h10 && fn <= 6'h1b)));
    if (op == 6'h00)
      dest = rd;
    else if (op == 6'h03)
      dest = 5'd31;
    else if ((op >= 6'h08 && op <= 6'h0f) || (op >= 6'h20 && op <= 6'h26))
      dest = rt;
    else
      dest = 5'd0;
  end
endmodule

module inst_issue_queue #(
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2,
  parameter int DEPTH   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [FETCH_W-1:0]       in_valid,
  input  logic [FETCH_W*32-1:0]    in_inst,
  input  logic [FETCH_W*32-1:0]    in_pc,
  output logic                     in_ready,
  output logic [ISSUE_W-1:0]       out_valid,
  output logic [ISSUE_W*32-1:0]    out_inst,
  output logic [ISSUE_W*32-1:0]    out_pc,
  output logic [ISSUE_W-1:0]       out_is_br,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] FETCH_C = CW'(FETCH_W);

  logic [AW-1:0]              head, tail;
  logic [CW-1:0]              cnt;
  logic [DEPTH-1:0][31:0]     q_inst, q_pc;
  logic [CW-1:0]              enq_n, deq_n;
  logic                       do_enq, do_deq;

  logic [ISSUE_W-1:0]         br, ser;
  logic [ISSUE_W-1:0][4:0]    dest, rs, rt;

  assign count    = cnt;
  // Credit comes from registered occupancy only; a same-cycle pop does not help.
  assign in_ready = (DEPTH_C - cnt) >= FETCH_C;
  assign do_enq   = in_ready & (|in_valid) & ~flush;
  assign do_deq   = out_ready & ~flush;

  // Read ports: slot s looks at head+s; decode each slot independently.
  for (genvar s = 0; s < ISSUE_W; s++) begin : g_slot
    logic [AW-1:0] idx;
    assign idx                 = head + AW'(s);
    assign out_inst[32*s +: 32] = q_inst[idx];
    assign out_pc[32*s +: 32]   = q_pc[idx];
    assign out_is_br[s]         = br[s];

    iiq_decode u_dec (
      .inst   (q_inst[idx]),
      .is_br  (br[s]),
      .is_ser (ser[s]),
      .dest   (dest[s]),
      .rs     (rs[s]),
      .rt     (rt[s])
    );
  end

  // Issue rules: single-issue just needs an entry; dual-issue holds a lone
  // branch until its delay slot arrives and splits hazardous pairs.
  if (ISSUE_W == 1) begin : g_w1
    logic unused_w1;
    assign out_valid = cnt != '0;
    assign unused_w1 = ^{br, ser, dest, rs, rt};
  end else begin : g_w2
    logic v0, raw, unused_w2;
    assign v0        = (cnt != '0) && !(br[0] && cnt == CW'(1));
    assign raw       = (dest[0] != 5'd0) && (rs[1] == dest[0] || rt[1] == dest[0]);
    assign out_valid = {v0 && (cnt >= CW'(2)) && !ser[0] && !ser[1] && !br[1] && !raw, v0};
    assign unused_w2 = ^{rs[0], rt[0], dest[1]};
  end

  // Lane/slot popcounts; lanes and slots are contiguous from 0.
  always_comb begin
    enq_n = '0;
    deq_n = '0;
    for (int l = 0; l < FETCH_W; l++) enq_n = enq_n + CW'(in_valid[l]);
    for (int s = 0; s < ISSUE_W; s++) deq_n = deq_n + CW'(out_valid[s]);
  end

  // Pointer, occupancy and storage update; reset wins over flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      head   <= '0;
      tail   <= '0;
      cnt    <= '0;
      q_inst <= '0;
      q_pc   <= '0;
    end else if (flush) begin
      head <= tail;
      cnt  <= '0;
    end else begin
      if (do_enq) begin
        for (int l = 0; l < FETCH_W; l++) begin
          if (in_valid[l]) begin
            q_inst[tail + AW'(l)] <= in_inst[32*l +: 32];
            q_pc[tail + AW'(l)]   <= in_pc[32*l +: 32];
          end
        end
        tail <= tail + enq_n[AW-1:0];
      end
      if (do_deq) head <= head + deq_n[AW-1:0];
      cnt <= cnt + (do_enq ? enq_n : '0) - (do_deq ? deq_n : '0);
    end
  end
endmodule

// File: tb/tb_inst_issue_queue.sv
// Self-checking bench for inst_issue_queue (FETCH_W=2, ISSUE_W=2, DEPTH=8).
// Reference model: a queue of {inst,pc} entries with issue rules computed
// straight from the instruction classes.
module tb_inst_issue_queue;
  localparam int FETCH_W = 2;
  localparam int ISSUE_W = 2;
  localparam int DEPTH   = 8;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic [1:0]  in_valid;
  logic [63:0] in_inst, in_pc;
  logic        in_ready;
  logic [1:0]  out_valid, out_is_br;
  logic [63:0] out_inst, out_pc;
  logic        out_ready;
  logic [3:0]  count;

  int ntests = 0;
  int nfail  = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;
  ent_t mq[$];

  inst_issue_queue #(.FETCH_W(FETCH_W), .ISSUE_W(ISSUE_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc), .in_ready(in_ready),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
    .out_is_br(out_is_br), .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  // ---- instruction encoders and class rules ----
  function automatic logic [31:0] addu(int d, int s, int t);
    return {6'h00, 5'(s), 5'(t), 5'(d), 5'h00, 6'h21};
  endfunction
  function automatic logic [31:0] beq(int s, int t);
    return {6'h04, 5'(s), 5'(t), 16'h0004};
  endfunction
  function automatic logic [31:0] mult(int s, int t);
    return {6'h00, 5'(s), 5'(t), 5'h00, 5'h00, 6'h18};
  endfunction
  function automatic logic [31:0] mfc0(int t, int d);
    return {6'h10, 5'h00, 5'(t), 5'(d), 11'h000};
  endfunction

  function automatic bit f_br(logic [31:0] i);
    return (i[31:26] >= 6'h01 && i[31:26] <= 6'h07) ||
           (i[31:26] == 6'h00 && (i[5:0] == 6'h08 || i[5:0] == 6'h09));
  endfunction
  function automatic bit f_ser(logic [31:0] i);
    return i[31:26] == 6'h10 || i[31:26] == 6'h1c ||
           (i[31:26] == 6'h00 && (i[5:0] == 6'h0c || i[5:0] == 6'h0d ||
                                  (i[5:0] >= 6'h10 && i[5:0] <= 6'h1b)));
  endfunction
  function automatic logic [4:0] f_dest(logic [31:0] i);
    if (i[31:26] == 6'h00) return i[15:11];
    if (i[31:26] == 6'h03) return 5'd31;
    if ((i[31:26] >= 6'h08 && i[31:26] <= 6'h0f) ||
        (i[31:26] >= 6'h20 && i[31:26] <= 6'h26)) return i[20:16];
    return 5'd0;
  endfunction

  // Expected issue vector from the model queue contents.
  function automatic logic [1:0] exp_valid();
    logic [31:0] a, b;
    logic [4:0]  d0;
    if (mq.size() == 0) return 2'b00;
    a = mq[0].inst;
    if (mq.size() == 1) return f_br(a) ? 2'b00 : 2'b01;
    b  = mq[1].inst;
    d0 = f_dest(a);
    if (f_ser(a) || f_ser(b) || f_br(b)) return 2'b01;
    if (d0 != 5'd0 && (b[25:21] == d0 || b[20:16] == d0)) return 2'b01;
    return 2'b11;
  endfunction

  function automatic logic [31:0] rand_inst();
    int k;
    k = $urandom_range(0, 9);
    case (k)
      5:       return beq($urandom_range(0, 7), $urandom_range(0, 7));
      6:       return {6'h03, 26'($urandom)};
      7:       return mult($urandom_range(0, 7), $urandom_range(0, 7));
      8:       return mfc0($urandom_range(0, 7), 12);
      9:       return {6'h23, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'h0010};
      default: return addu($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
    endcase
  endfunction

  task automatic set_in(logic [1:0] v, logic [31:0] i0, logic [31:0] i1,
                        logic [31:0] p0, logic [31:0] p1);
    in_valid = v;
    in_inst  = {i1, i0};
    in_pc    = {p1, p0};
  endtask

  // One clock edge; the model advances with the same inputs the DUT sees.
  task automatic tick();
    logic [1:0] ev;
    bit rdy;
    ev  = exp_valid();
    rdy = (DEPTH - mq.size()) >= FETCH_W;
    @(posedge clk);
    if (reset || flush) begin
      mq.delete();
    end else begin
      if (out_ready) begin
        for (int s = 0; s < ISSUE_W; s++) if (ev[s]) void'(mq.pop_front());
      end
      if (rdy && |in_valid) begin
        for (int l = 0; l < FETCH_W; l++)
          if (in_valid[l]) mq.push_back('{in_inst[32*l +: 32], in_pc[32*l +: 32]});
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    set_in(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    reset = 1'b0;
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    do_reset();
    tick();
    ntests++; if (count !== 4'd0) begin nfail++; $display("FAIL reset_count: got %0d want 0", count); end
    ntests++; if (in_ready !== 1'b1) begin nfail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    ntests++; if (out_valid !== 2'b00) begin nfail++; $display("FAIL reset_out_valid: got %b want 00", out_valid); end
    ntests++; if ($isunknown({out_inst, out_pc, out_is_br})) begin nfail++; $display("FAIL reset_no_x: got %h want known", out_inst); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int g = 0; g < 4; g++) begin
      set_in(2'b11, addu(3, 1, 2), addu(5, 4, 6), 32'(g * 8), 32'(g * 8 + 4));
      tick();
    end
    ntests++; if (count !== 4'd8) begin nfail++; $display("FAIL fill_count: got %0d want 8", count); end
    ntests++; if (in_ready !== 1'b0) begin nfail++; $display("FAIL fill_in_ready: got %b want 0", in_ready); end
    set_in(2'b11, addu(7, 1, 1), addu(8, 1, 1), 32'h100, 32'h104);
    tick();
    set_in(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    ntests++; if (count !== 4'd8) begin nfail++; $display("FAIL fill_drop_count: got %0d want 8", count); end
    ntests++; if (out_pc[31:0] !== 32'h0) begin nfail++; $display("FAIL fill_head_pc: got %h want 0", out_pc[31:0]); end
    // reset together with flush while full
    reset = 1'b1; flush = 1'b1; tick(); reset = 1'b0; flush = 1'b0;
    ntests++; if (count !== 4'd0 || in_ready !== 1'b1 || out_valid !== 2'b00) begin
      nfail++; $display("FAIL reset_mid: got cnt=%0d rdy=%b v=%b want 0/1/00", count, in_ready, out_valid); end
  endtask

  task automatic test_pair();
    do_reset();
    set_in(2'b11, addu(3, 1, 2), addu(5, 4, 6), 32'h10, 32'h14);
    tick();
    set_in(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    ntests++; if (out_valid !== 2'b11) begin nfail++; $display("FAIL pair_valid: got %b want 11", out_valid); end
    out_ready = 1'b1; tick();
    ntests++; if (count !== 4'd0) begin nfail++; $display("FAIL pair_count: got %0d want 0", count); end
  endtask

  task automatic test_raw();
    do_reset();
    set_in(2'b11, addu(3, 1, 2), addu(5, 3, 6), 32'h20, 32'h24);
    tick();
    set_in(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    ntests++; if (out_valid !== 2'b01) begin nfail++; $display("FAIL raw_split: got %b want 01", out_valid); end
    out_ready = 1'b1; tick();
    ntests++; if (count !== 4'd1 || out_valid !== 2'b01 || out_pc[31:0] !== 32'h24) begin
      nfail++; $display("FAIL raw_second: got cnt=%0d v=%b pc=%h want 1/01/24", count, out_valid, out_pc[31:0]); end
    tick();
    ntests++; if (count !== 4'd0) begin nfail++; $display("FAIL raw_drain: got %0d want 0", count); end
  endtask

  task automatic test_delay_slot();
    do_reset();
    out_ready = 1'b1;
    set_in(2'b01, beq(1, 2), 32'h0, 32'h30, 32'h0);
    tick();
    set_in(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    ntests++; if (count !== 4'd1 || out_valid !== 2'b00) begin
      nfail++; $display("FAIL ds_hold: got cnt=%0d v=%b want 1/00", count, out_valid); end
    tick();
    ntests++; if (out_valid !== 2'b00) begin nfail++; $display("FAIL ds_hold2: got %b want 00", out_valid); end
    set_in(2'b01, 32'h0, 32'h0, 32'h34, 32'h0);
    tick();
    set_in(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    ntests++; if (out_valid !== 2'b11 || out_is_br !== 2'b01) begin
      nfail++; $display("FAIL ds_pair: got v=%b br=%b want 11/01", out_valid, out_is_br); end
    tick();
    ntests++; if (count !== 4'd0) begin nfail++; $display("FAIL ds_drain: got %0d want 0", count); end
  endtask

  task automatic test_serial();
    do_reset();
    set_in(2'b11, mult(1, 2), addu(3, 4, 5), 32'h40, 32'h44);
    tick();
    set_in(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    ntests++; if (out_valid !== 2'b01) begin nfail++; $display("FAIL ser_slot0: got %b want 01", out_valid); end
    out_ready = 1'b1; tick();
    ntests++; if (out_valid !== 2'b01 || out_pc[31:0] !== 32'h44) begin
      nfail++; $display("FAIL ser_next: got v=%b pc=%h want 01/44", out_valid, out_pc[31:0]); end
    tick();
    out_ready = 1'b0;
    set_in(2'b11, addu(3, 1, 2), mfc0(4, 12), 32'h50, 32'h54);
    tick();
    set_in(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    ntests++; if (out_valid !== 2'b01) begin nfail++; $display("FAIL ser_mfc0_slot1: got %b want 01", out_valid); end
    out_ready = 1'b1; tick();
    ntests++; if (out_valid !== 2'b01 || out_pc[31:0] !== 32'h54) begin
      nfail++; $display("FAIL ser_mfc0_alone: got v=%b pc=%h want 01/54", out_valid, out_pc[31:0]); end
    tick();
  endtask

  // Random traffic across pointer wrap; PCs are a running sequence so issue
  // order can be checked independently of the model queue.
  task automatic test_random_wrap();
    int sent, cyc;
    logic [31:0] next_pc, exp_issue_pc;
    logic [1:0] ev;
    logic [31:0] i0, i1;
    do_reset();
    sent = 0; cyc = 0; next_pc = 32'h1000; exp_issue_pc = 32'h1000;
    while ((sent < 20 || mq.size() != 0) && cyc < 1000) begin
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 20 && $urandom_range(0, 2) != 0) begin
        i0 = (sent == 19) ? addu(1, 2, 3) : rand_inst();
        i1 = (sent == 19) ? addu(4, 5, 6) : rand_inst();
        set_in(2'b11, i0, i1, next_pc, next_pc + 4);
        if ((DEPTH - mq.size()) >= FETCH_W) begin sent++; next_pc += 8; end
      end else begin
        set_in(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
      end
      ev = exp_valid();
      ntests++; if (count !== 4'(mq.size()) || in_ready !== ((DEPTH - mq.size()) >= FETCH_W)) begin
        nfail++; $display("FAIL rnd_count: got cnt=%0d rdy=%b want %0d", count, in_ready, mq.size()); end
      ntests++; if (out_valid !== ev) begin nfail++; $display("FAIL rnd_valid: got %b want %b", out_valid, ev); end
      for (int s = 0; s < ISSUE_W; s++) begin
        if (ev[s]) begin
          ntests++;
          if (out_inst[32*s +: 32] !== mq[s].inst || out_pc[32*s +: 32] !== mq[s].pc ||
              out_is_br[s] !== f_br(mq[s].inst)) begin
            nfail++; $display("FAIL rnd_slot%0d: got %h@%h want %h@%h", s,
                              out_inst[32*s +: 32], out_pc[32*s +: 32], mq[s].inst, mq[s].pc);
          end
          if (out_ready) begin
            ntests++;
            if (mq[s].pc !== exp_issue_pc) begin
              nfail++; $display("FAIL rnd_order: got pc %h want %h", mq[s].pc, exp_issue_pc); end
            exp_issue_pc += 4;
          end
        end
      end
      tick();
      cyc++;
    end
    set_in(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    ntests++; if (count !== 4'd0 || exp_issue_pc !== 32'h1000 + 32'd160) begin
      nfail++; $display("FAIL rnd_drain: got cnt=%0d last=%h want 0/%h", count, exp_issue_pc, 32'h10a0); end
  endtask

  task automatic test_flush();
    do_reset();
    set_in(2'b11, addu(1, 2, 3), addu(4, 5, 6), 32'h60, 32'h64); tick();
    set_in(2'b11, addu(1, 2, 3), addu(4, 5, 6), 32'h68, 32'h6c); tick();
    set_in(2'b01, addu(1, 2, 3), 32'h0, 32'h70, 32'h0); tick();
    ntests++; if (count !== 4'd5) begin nfail++; $display("FAIL flush_pre: got %0d want 5", count); end
    flush = 1'b1; out_ready = 1'b1;
    set_in(2'b11, addu(7, 7, 7), addu(8, 8, 8), 32'h74, 32'h78);
    tick();
    flush = 1'b0;
    set_in(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    ntests++; if (count !== 4'd0 || out_valid !== 2'b00 || in_ready !== 1'b1) begin
      nfail++; $display("FAIL flush_clear: got cnt=%0d v=%b rdy=%b want 0/00/1", count, out_valid, in_ready); end
    out_ready = 1'b0;
    set_in(2'b11, addu(9, 1, 2), addu(10, 4, 6), 32'h80, 32'h84); tick();
    set_in(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    ntests++; if (out_valid !== 2'b11 || out_pc !== {32'h84, 32'h80}) begin
      nfail++; $display("FAIL flush_refill: got v=%b pc=%h want 11/%h", out_valid, out_pc, {32'h84, 32'h80}); end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    set_in(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    #2;
    test_reset();
    test_fill();
    test_pair();
    test_raw();
    test_delay_slot();
    test_serial();
    test_random_wrap();
    test_flush();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
